regfile_32x64: RTL and testbench
================================

Name: regfile_32x64

Overview:
- LEGv8 integer register file: 32 × 64-bit registers, two combinational read ports and one synchronous write port.
- Sits directly downstream of the write-select decode tree; the decoder's one-hot outputs gate the per-register write enables.
- Feeds ReadData1/ReadData2 to the ALU and datapath muxes.
- X31 (XZR) is hardwired to zero.

Parameters:
- DATA_WIDTH, 64, register width in bits.
- ADDR_WIDTH, 5, register index width; register count = 2**ADDR_WIDTH = 32.
- ZERO_REG, 31, index hardwired to zero.
- GATE_DELAY, 50, per-gate delay in ps for gate-level primitives (timescale 1ps/1ps).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- RegWrite  input  1  write enable.
- WriteRegister  input  ADDR_WIDTH  destination register index.
- WriteData  input  DATA_WIDTH  write value.
- ReadRegister1  input  ADDR_WIDTH  read port 1 index.
- ReadRegister2  input  ADDR_WIDTH  read port 2 index.
- ReadData1  output  DATA_WIDTH  contents of ReadRegister1.
- ReadData2  output  DATA_WIDTH  contents of ReadRegister2.

Behaviour:
- One clock (clk); reset is synchronous and active-high.
- Storage: 31 writable 64-bit registers (X0–X30) built from D flip-flops, each with a load mux (hold / load). X31 has no storage and drives constant 0.
- Write decode:
  - WriteRegister goes through a 5→32 decoder, enabled by RegWrite.
  - Output bit i is the load enable for register i.
  - Bit ZERO_REG is left unconnected.
- Write timing: at the rising edge of clk with RegWrite=1 and reset=0, register[WriteRegister] ← WriteData. All other registers hold.
- Reset:
  - At a rising edge with reset=1, every register is cleared to 0 regardless of RegWrite, WriteRegister or WriteData. Reset has priority over write.
  - Reset asserted mid-sequence discards that cycle's write.
  - Before the first reset edge, register contents are X; no X-suppression is required.
- Reset value of outputs: after the reset edge, ReadData1 = ReadData2 = 0 for every index, once the read-path delay has elapsed.
- Read:
  - Combinational: one 64-bit 32:1 mux per port, built as a tree of 4:1 mux stages using GATE_DELAY gates.
  - ReadDataN reflects the register contents as of the last clock edge. Latency is 0 cycles (gate delay only).
  - The read path must settle within half of the clock period the testbench uses.
- Boundary conditions:
  - Write to X31 is silently discarded; reading X31 always returns 0.
  - Both read ports may address the same register and both return the same value.
  - Read and write to the same index in the same cycle: the read returns the OLD value until the edge and the new value after it (unless the optional feature below is enabled).
  - RegWrite=0: no register changes, whatever the other write inputs carry.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - Write-through bypass on each read port: if RegWrite=1, reset=0, WriteRegister == ReadRegisterN and WriteRegister != ZERO_REG, then ReadDataN = WriteData combinationally in the same cycle.
  - Implemented as a 5-bit equality comparator plus a 2:1 mux per port.
- Not defined: no bypass; reads return stored contents only.

Decomposition:
- Shared package regfile_pkg holds:
  - constants DATA_WIDTH=64, ADDR_WIDTH=5, NUM_REGS=32, ZERO_REG=31, GATE_DELAY=50;
  - typedef reg_idx_t (logic [4:0]);
  - typedef word_t (logic [63:0]).
- One natural sub-module: deco5x32 (enable-gated 5→32 write decoder).
  - Composed of one 2→4 stage and four 3→8 stages.
  - Instantiated once, driven by WriteRegister and RegWrite.
- Read muxes are an internal generate structure, not a separate module.

Test Plan:
- Reset then read all: reset=1 for one edge, then sweep ReadRegister1/ReadRegister2 over 0–31 → every ReadData = 0.
- Write/read each register: for i in 0–30, write 64'h0123_4567_89AB_CD00 + i with RegWrite=1, then read back on both ports → exact value. X31 reads 0.
- Zero register: write 64'hFFFF_FFFF_FFFF_FFFF to X31 → ReadData1 with ReadRegister1=31 stays 0. X0–X30 are unchanged.
- Write enable off: write X5 = 64'hDEAD_BEEF_0000_0001, then drive RegWrite=0 with WriteData=64'h0 and WriteRegister=5 for 3 edges → X5 still 64'hDEAD_BEEF_0000_0001.
- Reset vs write: reset=1, RegWrite=1, WriteRegister=7, WriteData=64'h55 on the same edge → X7 reads 0 afterwards.
- Same-cycle read/write at X9 = 64'hA5:
  - REGFILE_BYPASS_EN defined: ReadData1 = 64'hA5 before the edge.
  - Undefined: ReadData1 holds the old value before the edge and 64'hA5 after it.

Source files
------------

// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared constants, types and a helper for the regfile_32x64 slice.
//   DATA_WIDTH : register width in bits (64)
//   ADDR_WIDTH : register index width (5)
//   NUM_REGS   : register count (32)
//   ZERO_REG   : index hardwired to zero (X31 / XZR)
//   GATE_DELAY : per-gate delay in ps used by gate-level netlists of this
//                block (timescale 1ps/1ps). The RTL itself is zero-delay.
// -----------------------------------------------------------------------------
package regfile_pkg;

  localparam int DATA_WIDTH = 64;
  localparam int ADDR_WIDTH = 5;
  localparam int NUM_REGS   = 2 ** ADDR_WIDTH;
  localparam int ZERO_REG   = 31;
  localparam int GATE_DELAY = 50;

  typedef logic [ADDR_WIDTH-1:0] reg_idx_t;
  typedef logic [DATA_WIDTH-1:0] word_t;

  // One 4:1 stage of the read mux tree.
  function automatic word_t mux4(input word_t a, input word_t b,
                                 input word_t c, input word_t d,
                                 input logic [1:0] sel);
    case (sel)
      2'd0:    return a;
      2'd1:    return b;
      2'd2:    return c;
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/regfile_32x64_if.sv
// -----------------------------------------------------------------------------
// regfile_32x64_if
// Write and read bus of the register file.
//   RegWrite      : write enable
//   WriteRegister : destination index
//   WriteData     : value to write
//   ReadRegister1 : read port 1 index
//   ReadRegister2 : read port 2 index
//   ReadData1     : contents of ReadRegister1
//   ReadData2     : contents of ReadRegister2
// Modports: master drives indices/write data, slave (the register file)
// drives read data.
//
// Transfer semantics: there is no valid/ready pair. A write is a single-cycle
// command: it takes effect at the rising clk edge where RegWrite=1 and
// reset=0, and is never back-pressured. Reads are combinational and always
// accepted: ReadDataN follows ReadRegisterN within the same cycle.
// -----------------------------------------------------------------------------
interface regfile_32x64_if
  import regfile_pkg::*;
();

  logic     RegWrite;
  reg_idx_t WriteRegister;
  word_t    WriteData;
  reg_idx_t ReadRegister1;
  reg_idx_t ReadRegister2;
  word_t    ReadData1;
  word_t    ReadData2;

  modport master (
    output RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
    input  ReadData1, ReadData2
  );

  modport slave (
    input  RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
    output ReadData1, ReadData2
  );

endinterface

// File: rtl/regfile_32x64_deco5x32.sv
// -----------------------------------------------------------------------------
// deco5x32
// Enable-gated 5->32 one-hot decoder for the register write enables.
//   en   : decoder enable (RegWrite)
//   addr : register index
//   y    : one-hot load enables, all zero when en=0
// Built as a 2->4 stage on addr[4:3] whose outputs enable four 3->8 stages
// on addr[2:0].
// -----------------------------------------------------------------------------
module deco5x32
  import regfile_pkg::*;
(
  input  logic              en,
  input  reg_idx_t          addr,
  output logic [NUM_REGS-1:0] y
);

  logic [3:0] hi;

  assign hi = en ? (4'b0001 << addr[4:3]) : 4'b0000;

  for (genvar b = 0; b < 4; b++) begin : g_lo
    assign y[8*b +: 8] = hi[b] ? (8'b0000_0001 << addr[2:0]) : 8'b0000_0000;
  end

endmodule

// File: rtl/regfile_32x64.sv
// -----------------------------------------------------------------------------
// regfile_32x64
// LEGv8 integer register file: 32 x 64-bit, two combinational read ports,
// one synchronous write port. X31 (XZR) has no storage and reads as zero.
//   clk   : rising-edge clock
//   reset : synchronous, active-high; clears X0..X30, wins over a write
//   bus   : regfile_32x64_if.slave (write command, read indices, read data)
// Optional build macro: REGFILE_BYPASS_EN adds a write-through bypass on each
// read port so a same-cycle write to the addressed register is visible
// before the edge. Without it, reads return stored contents only.
// -----------------------------------------------------------------------------
module regfile_32x64
  import regfile_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  regfile_32x64_if.slave         bus
);

  logic [NUM_REGS-1:0] load_en;
  word_t               regs [NUM_REGS-1];
  word_t               rows [NUM_REGS];
  reg_idx_t            rd_idx [2];
  word_t               rd_data [2];

  // The decoder output for X31 exists but drives nothing: writes there vanish.
  logic zero_reg_unused;

  deco5x32 u_deco (
    .en   (bus.RegWrite),
    .addr (bus.WriteRegister),
    .y    (load_en)
  );

  assign zero_reg_unused = load_en[ZERO_REG];

  // Storage: each writable register is a hold/load mux in front of its flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS - 1; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS - 1; i++) begin
        if (load_en[i]) begin
          regs[i] <= bus.WriteData;
        end
      end
    end
  end

  // Read sources: X31 is a constant zero row.
  for (genvar r = 0; r < NUM_REGS; r++) begin : g_rows
    if (r == ZERO_REG) begin : g_zero
      assign rows[r] = '0;
    end else begin : g_reg
      assign rows[r] = regs[r];
    end
  end

  assign rd_idx[0] = bus.ReadRegister1;
  assign rd_idx[1] = bus.ReadRegister2;

  // Per port: 8 x 4:1 on idx[1:0], 2 x 4:1 on idx[3:2], final 2:1 on idx[4].
  for (genvar p = 0; p < 2; p++) begin : g_port
    word_t s1 [8];
    word_t s2 [2];
    word_t tree_out;

    for (genvar g = 0; g < 8; g++) begin : g_s1
      assign s1[g] = mux4(rows[4*g], rows[4*g+1], rows[4*g+2], rows[4*g+3],
                          rd_idx[p][1:0]);
    end

    for (genvar g = 0; g < 2; g++) begin : g_s2
      assign s2[g] = mux4(s1[4*g], s1[4*g+1], s1[4*g+2], s1[4*g+3],
                          rd_idx[p][3:2]);
    end

    assign tree_out = rd_idx[p][4] ? s2[1] : s2[0];

`ifdef REGFILE_BYPASS_EN
    // Forward a write that will land at the next edge; never for XZR and
    // never while reset is about to clear the file.
    logic hit;
    assign hit = bus.RegWrite && !reset &&
                 (bus.WriteRegister == rd_idx[p]) &&
                 (bus.WriteRegister != reg_idx_t'(ZERO_REG));
    assign rd_data[p] = hit ? bus.WriteData : tree_out;
`else
    assign rd_data[p] = tree_out;
`endif
  end

  assign bus.ReadData1 = rd_data[0];
  assign bus.ReadData2 = rd_data[1];

endmodule

// File: tb/tb_regfile_32x64.sv
// -----------------------------------------------------------------------------
// tb_regfile_32x64
// Self-checking bench for regfile_32x64: a table of single-cycle vectors with
// hand-computed read results, plus directed sequences for reset sweep,
// per-register write/readback, XZR, write-enable off and same-cycle
// read/write. Honours REGFILE_BYPASS_EN for the same-cycle expectation.
// -----------------------------------------------------------------------------
`timescale 1ps/1ps
module tb_regfile_32x64;
  import regfile_pkg::*;

  localparam int CLK_PERIOD = 10000;

  typedef struct {
    logic     rst;
    logic     we;
    reg_idx_t wa;
    word_t    wd;
    reg_idx_t ra1;
    reg_idx_t ra2;
    word_t    exp1;
    word_t    exp2;
  } vec_t;

  logic  clk;
  logic  reset;
  int    checks;
  int    errors;
  word_t model [NUM_REGS];
  logic [DATA_WIDTH-1:0] exp_q [$];
  vec_t  vecs [7];

  regfile_32x64_if rf_if ();

  regfile_32x64 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (rf_if)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #(CLK_PERIOD / 2) clk = ~clk;
  end

  // Watchdog: the bench is a fixed sequence, so this only trips on a hang.
  initial begin
    #(CLK_PERIOD * 2000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input reg_idx_t wa, input word_t wd);
    rf_if.RegWrite      = 1'b1;
    rf_if.WriteRegister = wa;
    rf_if.WriteData     = wd;
    tick();
    rf_if.RegWrite = 1'b0;
    if (wa != reg_idx_t'(ZERO_REG)) model[wa] = wd;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input word_t act);
    word_t exp;
    exp = exp_q.pop_front();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sweep(input string name);
    for (int i = 0; i < NUM_REGS; i++) begin
      rf_if.ReadRegister1 = reg_idx_t'(i);
      rf_if.ReadRegister2 = reg_idx_t'(NUM_REGS - 1 - i);
      exp_q.push_back(model[i]);
      exp_q.push_back(model[NUM_REGS - 1 - i]);
      #1;
      check($sformatf("%s rd1 x%0d", name, i), rf_if.ReadData1);
      check($sformatf("%s rd2 x%0d", name, NUM_REGS - 1 - i), rf_if.ReadData2);
    end
  endtask

  // ---------------- test ----------------
  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    rf_if.RegWrite      = 1'b0;
    rf_if.WriteRegister = '0;
    rf_if.WriteData     = '0;
    rf_if.ReadRegister1 = '0;
    rf_if.ReadRegister2 = '0;
    for (int i = 0; i < NUM_REGS; i++) model[i] = '0;

    // Vector table: inputs held across one edge, reads sampled 1ps after it.
    vecs[0] = '{rst:1'b1, we:1'b1, wa:5'd7,  wd:64'h55,
                ra1:5'd7,  ra2:5'd0,  exp1:64'h0, exp2:64'h0};
    vecs[1] = '{rst:1'b0, we:1'b1, wa:5'd3,  wd:64'h1111,
                ra1:5'd3,  ra2:5'd3,  exp1:64'h1111, exp2:64'h1111};
    vecs[2] = '{rst:1'b0, we:1'b1, wa:5'd31, wd:64'hFFFF_FFFF_FFFF_FFFF,
                ra1:5'd31, ra2:5'd3,  exp1:64'h0, exp2:64'h1111};
    vecs[3] = '{rst:1'b0, we:1'b0, wa:5'd3,  wd:64'h0,
                ra1:5'd3,  ra2:5'd31, exp1:64'h1111, exp2:64'h0};
    vecs[4] = '{rst:1'b0, we:1'b1, wa:5'd0,  wd:64'h8000_0000_0000_0001,
                ra1:5'd0,  ra2:5'd3,  exp1:64'h8000_0000_0000_0001, exp2:64'h1111};
    vecs[5] = '{rst:1'b0, we:1'b1, wa:5'd30, wd:64'hCAFE,
                ra1:5'd30, ra2:5'd0,  exp1:64'hCAFE, exp2:64'h8000_0000_0000_0001};
    vecs[6] = '{rst:1'b1, we:1'b0, wa:5'd30, wd:64'h0,
                ra1:5'd30, ra2:5'd3,  exp1:64'h0, exp2:64'h0};

    // Reset then read every index on both ports.
    do_reset();
    sweep("reset");

    // Table-driven vectors.
    for (int v = 0; v < 7; v++) begin
      reset               = vecs[v].rst;
      rf_if.RegWrite      = vecs[v].we;
      rf_if.WriteRegister = vecs[v].wa;
      rf_if.WriteData     = vecs[v].wd;
      rf_if.ReadRegister1 = vecs[v].ra1;
      rf_if.ReadRegister2 = vecs[v].ra2;
      tick();
      exp_q.push_back(vecs[v].exp1);
      exp_q.push_back(vecs[v].exp2);
      check($sformatf("vec%0d rd1", v), rf_if.ReadData1);
      check($sformatf("vec%0d rd2", v), rf_if.ReadData2);
    end
    reset          = 1'b0;
    rf_if.RegWrite = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) model[i] = '0;

    // Write each register with a distinct pattern, then read all back.
    for (int i = 0; i < NUM_REGS - 1; i++) begin
      do_write(reg_idx_t'(i), 64'h0123_4567_89AB_CD00 + word_t'(i));
    end
    sweep("wr_all");

    // XZR write is discarded; nothing else moves.
    do_write(reg_idx_t'(ZERO_REG), 64'hFFFF_FFFF_FFFF_FFFF);
    sweep("xzr");

    // Write enable off for three edges with conflicting write inputs.
    do_write(5'd5, 64'hDEAD_BEEF_0000_0001);
    rf_if.RegWrite      = 1'b0;
    rf_if.WriteRegister = 5'd5;
    rf_if.WriteData     = 64'h0;
    for (int i = 0; i < 3; i++) tick();
    rf_if.ReadRegister1 = 5'd5;
    rf_if.ReadRegister2 = 5'd5;
    #1;
    exp_q.push_back(64'hDEAD_BEEF_0000_0001);
    exp_q.push_back(64'hDEAD_BEEF_0000_0001);
    check("we_off rd1", rf_if.ReadData1);
    check("we_off rd2", rf_if.ReadData2);

    // Same-cycle read/write of X9.
    rf_if.ReadRegister1 = 5'd9;
    rf_if.ReadRegister2 = 5'd10;
    rf_if.RegWrite      = 1'b1;
    rf_if.WriteRegister = 5'd9;
    rf_if.WriteData     = 64'hA5;
    #1;
`ifdef REGFILE_BYPASS_EN
    exp_q.push_back(64'hA5);
`else
    exp_q.push_back(model[9]);
`endif
    exp_q.push_back(model[10]);
    check("same_cycle pre rd1", rf_if.ReadData1);
    check("same_cycle pre rd2", rf_if.ReadData2);
    tick();
    rf_if.RegWrite = 1'b0;
    model[9] = 64'hA5;
    #1;
    exp_q.push_back(64'hA5);
    exp_q.push_back(model[10]);
    check("same_cycle post rd1", rf_if.ReadData1);
    check("same_cycle post rd2", rf_if.ReadData2);

    // Final full readback after all the corner cases.
    sweep("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
